timer_bus_arbiter: RTL
======================

TIMER_BUS_ARBITER -- requirements
Module: timer_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of requesters sharing one timer_periph slave port (range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 15, maximum cycles to wait for slave gnt (range 1..255).
REQ-003 SHALL take P_ADDR_WIDTH and P_DATA_WIDTH from design_params_pkg.
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 m_req  input  N_MASTERS  per-master request; held high until matching m_gnt.
REQ-007 m_write_en  input  N_MASTERS  per-master write (1) / read (0).
REQ-008 m_addr  input  N_MASTERS*P_ADDR_WIDTH  per-master packed address.
REQ-009 m_wdata  input  N_MASTERS*P_DATA_WIDTH  per-master packed write data.
REQ-010 m_gnt  output  N_MASTERS  one-hot, one-cycle completion pulse.
REQ-011 m_rdata  output  P_DATA_WIDTH  read data, valid only in the m_gnt cycle.
REQ-012 m_err  output  1  timeout flag, valid only in the m_gnt cycle.
REQ-013 s_req, s_write_en  output  1 each; s_addr  output  P_ADDR_WIDTH; s_wdata  output  P_DATA_WIDTH; all drive the timer slave.
REQ-014 s_gnt  input  1; s_rdata  input  P_DATA_WIDTH; slave gnt pulse and read data, both valid in the same cycle.
REQ-015 busy  output  1; owner  output  $clog2(N_MASTERS); transaction in flight and the owning master index.

Function
REQ-016 SHALL implement FSM ARB_IDLE, ARB_WAIT, ARB_RESP.
REQ-017 ARB_IDLE, any m_req high: select the first requesting index at or after rr_ptr, wrapping modulo N_MASTERS; latch index, addr, wdata, write_en; go to ARB_WAIT next cycle.
REQ-018 ARB_WAIT: s_req=1 and s_addr/s_wdata/s_write_en driven from latched values, constant for the whole state.
REQ-019 ARB_WAIT, s_gnt=1: capture s_rdata (masked to 0 on writes), go to ARB_RESP.
REQ-020 ARB_RESP: exactly one cycle; m_gnt[owner]=1, m_rdata=captured data, s_req=0; rr_ptr <= (owner+1) mod N_MASTERS; then ARB_IDLE.
REQ-021 ARB_WAIT, m_req[owner] dropped and s_gnt=0: abort; s_req=0 next cycle, no m_gnt, rr_ptr unchanged, go to ARB_IDLE.
REQ-022 m_req[owner] drop in the same cycle as s_gnt=1: grant wins; complete through ARB_RESP with normal m_gnt.
REQ-023 Request-to-m_gnt latency SHALL be 1 (arbitration) + slave grant delay + 1 (response) cycles.
REQ-024 A new arbitration SHALL NOT start in the ARB_RESP cycle; minimum 1 idle cycle with s_req=0 between slave transactions.
REQ-025 Requests arriving during a transaction SHALL be held pending, never dropped; with continuous requests from all masters, each master is served once per N_MASTERS transactions.
REQ-026 busy=1 in ARB_WAIT and ARB_RESP; owner is valid while busy, else 0.
REQ-027 m_gnt SHALL be one-hot or zero; s_req SHALL never be high in ARB_IDLE or ARB_RESP.

Reset
REQ-028 While reset is high: state ARB_IDLE; rr_ptr=0; m_gnt=0, m_rdata=0, m_err=0, s_req=0, s_write_en=0, s_addr=0, s_wdata=0, busy=0, owner=0, wait counter=0.
REQ-029 Reset asserted mid-transaction SHALL drop s_req asynchronously; no m_gnt is issued for the lost transaction.

Configuration
REQ-030 Macro TIMER_ARB_TIMEOUT_EN defined: an 8-bit wait counter clears on entering ARB_WAIT; if s_gnt is absent for TIMEOUT_CYC cycles, drop s_req and go to ARB_RESP with m_err=1 and m_rdata=0.
REQ-031 Macro undefined: no counter; ARB_WAIT waits indefinitely; m_err is tied 0.

Verification
REQ-032 Single read: master 0 reads addr STATUS, slave gnt after 2 cycles with s_rdata=0x1 -> m_gnt[0] pulse 1 cycle, m_rdata=0x1, latency 4 cycles.
REQ-033 Contention: masters 0 and 1 request in the same cycle after reset -> master 0 served first, master 1 next; rr_ptr=0 at finish.
REQ-034 Back-to-back: master 1 holds requests for 3 transactions while master 0 requests once -> order 1,0,1,1 or 0,1,...; never two consecutive grants to one master while the other is pending.
REQ-035 Abort: master 0 drops m_req 1 cycle into ARB_WAIT with s_gnt=0 -> s_req falls, no m_gnt; abort concurrent with s_gnt -> m_gnt[0] still pulses.
REQ-036 Timeout (macro defined, TIMEOUT_CYC=4): slave never grants -> s_req drops after 4 wait cycles, m_gnt[0]=1 with m_err=1, m_rdata=0.
REQ-037 Reset asserted in ARB_WAIT -> s_req=0 immediately, busy=0, and after release the first grant follows rr_ptr=0.

Source files
------------

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing one timer_periph slave port among N_MASTERS requesters.
// Optional slave-grant timeout is compiled in when TIMER_ARB_TIMEOUT_EN is defined.
package design_params_pkg;
  localparam int P_ADDR_WIDTH = 8;
  localparam int P_DATA_WIDTH = 16;
endpackage

module timer_bus_arbiter
  import design_params_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_MASTERS-1:0]              m_req,
  input  logic [N_MASTERS-1:0]              m_write_en,
  input  logic [N_MASTERS*P_ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MASTERS*P_DATA_WIDTH-1:0] m_wdata,
  output logic [N_MASTERS-1:0]              m_gnt,
  output logic [P_DATA_WIDTH-1:0]           m_rdata,
  output logic                              m_err,
  output logic                              s_req,
  output logic                              s_write_en,
  output logic [P_ADDR_WIDTH-1:0]           s_addr,
  output logic [P_DATA_WIDTH-1:0]           s_wdata,
  input  logic                              s_gnt,
  input  logic [P_DATA_WIDTH-1:0]           s_rdata,
  output logic                              busy,
  output logic [$clog2(N_MASTERS)-1:0]      owner
);
  localparam int IW = $clog2(N_MASTERS);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  arb_state_t    state_r;
  logic [IW-1:0] rr_ptr_r;
  logic [IW-1:0] pick_s;
  logic [IW-1:0] cand_s;
  logic          found_s;

  if (N_MASTERS < 2 || N_MASTERS > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_params
    $error("timer_bus_arbiter: parameter out of range");
  end

  function automatic logic [N_MASTERS-1:0] one_hot(input logic [IW-1:0] idx);
    one_hot = {{(N_MASTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
  always_comb begin
    pick_s  = '0;
    cand_s  = '0;
    found_s = |m_req;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      cand_s = IW'((int'(rr_ptr_r) + i) % N_MASTERS);
      if (m_req[cand_s]) begin
        pick_s = cand_s;
      end else begin
        pick_s = pick_s;
      end
    end
  end

`ifdef TIMER_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt_r;
`else
  assign m_err = 1'b0;
`endif

  // Arbitration FSM; all master- and slave-facing outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ARB_IDLE;
      rr_ptr_r   <= '0;
      m_gnt      <= '0;
      m_rdata    <= '0;
      s_req      <= 1'b0;
      s_write_en <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      busy       <= 1'b0;
      owner      <= '0;
`ifdef TIMER_ARB_TIMEOUT_EN
      m_err      <= 1'b0;
      wait_cnt_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (found_s) begin
            state_r    <= ARB_WAIT;
            owner      <= pick_s;
            busy       <= 1'b1;
            s_req      <= 1'b1;
            s_write_en <= m_write_en[pick_s];
            s_addr     <= m_addr[int'(pick_s)*P_ADDR_WIDTH +: P_ADDR_WIDTH];
            s_wdata    <= m_wdata[int'(pick_s)*P_DATA_WIDTH +: P_DATA_WIDTH];
`ifdef TIMER_ARB_TIMEOUT_EN
            wait_cnt_r <= 8'd0;
`endif
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_WAIT: begin
          // A slave grant outranks a simultaneous request drop.
          if (s_gnt) begin
            state_r <= ARB_RESP;
            s_req   <= 1'b0;
            m_gnt   <= one_hot(owner);
            m_rdata <= s_write_en ? '0 : s_rdata;
          end else if (!m_req[owner]) begin
            state_r <= ARB_IDLE;
            s_req   <= 1'b0;
            busy    <= 1'b0;
            owner   <= '0;
          end
`ifdef TIMER_ARB_TIMEOUT_EN
          else if (wait_cnt_r == TIMEOUT_LAST) begin
            state_r <= ARB_RESP;
            s_req   <= 1'b0;
            m_gnt   <= one_hot(owner);
            m_rdata <= '0;
            m_err   <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
`else
          else begin
            state_r <= ARB_WAIT;
          end
`endif
        end
        ARB_RESP: begin
          state_r  <= ARB_IDLE;
          m_gnt    <= '0;
          m_rdata  <= '0;
          busy     <= 1'b0;
          owner    <= '0;
          rr_ptr_r <= IW'((int'(owner) + 1) % N_MASTERS);
`ifdef TIMER_ARB_TIMEOUT_EN
          m_err    <= 1'b0;
`endif
        end
        default: begin
          state_r <= ARB_IDLE;
          s_req   <= 1'b0;
          m_gnt   <= '0;
          busy    <= 1'b0;
          owner   <= '0;
        end
      endcase
    end
  end

endmodule
